// File: rtl/fx_convert_pipe_pkg.sv
// Shared definitions for the fixed-point converter: rounding-mode encodings
// and the width of the intermediate (post-rounding) value.
package fx_pkg;

  typedef enum logic [1:0] {
    FX_RND_TRUNC = 2'd0,
    FX_RND_RHU   = 2'd1,
    FX_RND_RNE   = 2'd2,
    FX_RND_RTZ   = 2'd3
  } fx_rnd_e;

  // IW-SH+1 holds the kept field plus one carry bit, so the rounding add never
  // wraps; the floor of 2 covers SH==IW where the kept field is only the sign.
  function automatic int fx_rnd_width(input int iw, input int sh);
    int w;
    w = iw - sh + 1;
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/fx_convert_pipe_if.sv
// Sample/control bundle of the converter; master drives the i_* side,
// slave is the converter itself.
interface fx_convert_pipe_if #(
  parameter int IW = 13,
  parameter int OW = 14,
  parameter int CW = 16
);
  logic          i_valid;
  logic [IW-1:0] i_data;
  logic [1:0]    i_rnd_mode;
  logic          i_sat_en;
  logic          i_cnt_clr;
  logic          o_valid;
  logic [OW-1:0] o_data;
  logic          o_ovf;
  logic [CW-1:0] o_ovf_cnt;

  modport master (
    output i_valid, i_data, i_rnd_mode, i_sat_en, i_cnt_clr,
    input  o_valid, o_data, o_ovf, o_ovf_cnt
  );

  modport slave (
    input  i_valid, i_data, i_rnd_mode, i_sat_en, i_cnt_clr,
    output o_valid, o_data, o_ovf, o_ovf_cnt
  );
endinterface

// File: rtl/fx_convert_pipe_delay_line.sv
// Parametric WIDTH x DEPTH shift register with synchronous active-low reset;
// DEPTH=0 degenerates to a wire.
module fx_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_d
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst_n;
    assign o_d = i_d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end

    assign o_d = r_pipe[DEPTH-1];
  end

endmodule

// File: rtl/fx_convert_pipe.sv
// Pipelined signed fixed-point re-quantiser (IW,IF) -> (OW,OF) with run-time
// rounding mode, saturate/wrap overflow handling and an overflow-event counter.
module fx_convert_pipe
  import fx_pkg::*;
#(
  parameter int IW  = 13,
  parameter int IF  = 8,
  parameter int OW  = 14,
  parameter int OF  = 8,
  parameter int LAT = 2,
  parameter int CW  = 16
) (
  input logic              clk,
  input logic              rst_n,
  fx_convert_pipe_if.slave bus
);

  localparam int SH = IF - OF;
  localparam int RW = fx_rnd_width(IW, SH);

  logic signed [IW:0]   w_ext;
  logic signed [RW-1:0] w_rnd;

  assign w_ext = {bus.i_data[IW-1], bus.i_data};

  if (SH > 0) begin : g_rnd
    localparam logic [SH-1:0] HALF = SH'(1) << (SH - 1);

    logic signed [RW-1:0] w_k;
    logic [SH-1:0]        w_d;
    logic                 w_inc;

    assign w_k = RW'(w_ext >>> SH);
    assign w_d = bus.i_data[SH-1:0];

    always_comb begin
      w_inc = 1'b0;
      case (fx_rnd_e'(bus.i_rnd_mode))
        FX_RND_TRUNC: w_inc = 1'b0;
        FX_RND_RHU:   w_inc = w_d[SH-1];
        FX_RND_RNE:   w_inc = (w_d > HALF) || ((w_d == HALF) && w_k[0]);
        FX_RND_RTZ:   w_inc = w_k[RW-1] && (w_d != '0);
        default:      w_inc = 1'b0;
      endcase
    end

    assign w_rnd = w_k + $signed({{(RW-1){1'b0}}, w_inc});
  end else begin : g_shl
    // Widening or equal fraction: exact left shift, rounding mode irrelevant.
    logic [1:0] w_unused_mode;
    assign w_unused_mode = bus.i_rnd_mode;
    assign w_rnd = RW'(w_ext) <<< (-SH);
  end

  logic                 r_s1_val;
  logic                 r_s1_sat;
  logic signed [RW-1:0] r_s1_rnd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_val <= 1'b0;
      r_s1_sat <= 1'b0;
      r_s1_rnd <= '0;
    end else begin
      r_s1_val <= bus.i_valid;
      r_s1_sat <= bus.i_sat_en;
      r_s1_rnd <= w_rnd;
    end
  end

  logic          w_ovf;
  logic [OW-1:0] w_res;

  if (RW > OW) begin : g_ovf
    // In range iff every bit above the output sign matches the true sign.
    logic          w_neg;
    logic [RW-OW-1:0] w_hi;

    assign w_neg = r_s1_rnd[RW-1];
    assign w_hi  = r_s1_rnd[RW-2:OW-1];
    assign w_ovf = w_neg ? !(&w_hi) : (|w_hi);

    always_comb begin
      w_res = r_s1_rnd[OW-1:0];
      if (w_ovf && r_s1_sat)
        w_res = w_neg ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end
  end else begin : g_fit
    logic w_unused_sat;
    assign w_unused_sat = r_s1_sat;
    assign w_ovf = 1'b0;
    assign w_res = OW'(r_s1_rnd);
  end

  logic          r_s2_val;
  logic          r_s2_ovf;
  logic [OW-1:0] r_s2_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_val  <= 1'b0;
      r_s2_ovf  <= 1'b0;
      r_s2_data <= '0;
    end else begin
      r_s2_val  <= r_s1_val;
      r_s2_ovf  <= r_s1_val & w_ovf;
      r_s2_data <= w_res;
    end
  end

  logic [OW+1:0] w_dly;

  fx_delay_line #(
    .WIDTH (OW + 2),
    .DEPTH (LAT - 2)
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({r_s2_val, r_s2_ovf, r_s2_data}),
    .o_d   (w_dly)
  );

  assign bus.o_valid = w_dly[OW+1];
  assign bus.o_ovf   = w_dly[OW];
  assign bus.o_data  = w_dly[OW-1:0];

  logic [CW-1:0] r_cnt;

  // Clear wins over a same-cycle increment; count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (bus.i_cnt_clr)
      r_cnt <= '0;
    else if (bus.o_valid && bus.o_ovf && !(&r_cnt))
      r_cnt <= r_cnt + CW'(1);
  end

  assign bus.o_ovf_cnt = r_cnt;

endmodule
